sreg_host_bridge: RTL and testbench

- Sits directly upstream of the shift-register controller.
- Converts a host byte stream from the UART receiver into one command handshake on the controller's cmd_valid/cmd/data_in interface, then waits for the command to complete.
- Returns status, plus the 42-bit readback word, to the UART transmitter as bytes.
- Sole master of the controller's command port.

---
 rtl/sreg_host_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_sreg_host_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_host_bridge.sv
// Host byte-stream bridge: decodes UART frames into one controller command,
// waits for completion, then streams status and readback bytes back to the host.
`timescale 1ns/1ps
module sreg_host_bridge #(
  parameter int unsigned DATA_W       = 42,
  parameter int unsigned RX_TIMEOUT   = 1000000,
  parameter int unsigned DONE_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  output logic [DATA_W-1:0] data_in,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              rx_drop
);

  localparam int unsigned PAYLOAD_BYTES = (DATA_W + 7) / 8;
  localparam int unsigned SR_W          = PAYLOAD_BYTES * 8;
  localparam int unsigned CNT_W         = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned GAP_W         = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned DONE_W        = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_PAYLOAD,
    ISSUE,
    WAIT_DONE,
    SEND_RESP
  } state_t;

  state_t              state, state_d;
  logic [DATA_W-9:0]   sr, sr_d;
  logic [DATA_W-1:0]   sr_next;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_d;
  logic [GAP_W-1:0]    gap_cnt, gap_d;
  logic [DONE_W-1:0]   done_cnt, done_d;
  logic [SR_W-1:0]     tx_buf, tx_buf_d;
  logic [CNT_W-1:0]    tx_rem, tx_rem_d;
  logic [7:0]          tx_data_d;
  logic                tx_valid_d, cmd_valid_d, rx_drop_d;
  logic [2:0]          cmd_d;
  logic [DATA_W-1:0]   data_in_d;

  assign busy = (state != IDLE);

  always_comb begin
    state_d     = state;
    sr_d        = sr;
    byte_cnt_d  = byte_cnt;
    gap_d       = gap_cnt;
    done_d      = done_cnt;
    tx_buf_d    = tx_buf;
    tx_rem_d    = tx_rem;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    cmd_valid_d = cmd_valid;
    cmd_d       = cmd;
    data_in_d   = data_in;
    rx_drop_d   = rx_drop;
    // Only the low DATA_W bits of the payload survive, so bytes shifted past
    // the top are discarded as they arrive rather than truncated at the end.
    sr_next     = {sr, rx_data};

    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h00: begin
              cmd_d       = 3'd0;
              cmd_valid_d = 1'b1;
              state_d     = ISSUE;
            end
            8'h01: begin
              sr_d       = '0;
              byte_cnt_d = '0;
              gap_d      = '0;
              state_d    = GET_PAYLOAD;
            end
            default: begin
              tx_data_d  = 8'hEE;
              tx_valid_d = 1'b1;
              tx_rem_d   = '0;
              state_d    = SEND_RESP;
            end
          endcase
        end
      end

      GET_PAYLOAD: begin
        if (gap_cnt == GAP_W'(RX_TIMEOUT)) begin
          sr_d       = '0;
          byte_cnt_d = '0;
          rx_drop_d  = rx_drop | rx_valid;
          tx_data_d  = 8'hE0;
          tx_valid_d = 1'b1;
          tx_rem_d   = '0;
          state_d    = SEND_RESP;
        end else if (rx_valid) begin
          sr_d       = sr_next[DATA_W-9:0];
          gap_d      = '0;
          byte_cnt_d = byte_cnt + 1'b1;
          if (byte_cnt == CNT_W'(PAYLOAD_BYTES - 1)) begin
            data_in_d   = sr_next;
            cmd_d       = 3'd1;
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
          end
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end

      ISSUE: begin
        rx_drop_d = rx_drop | rx_valid;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          done_d      = '0;
          state_d     = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        rx_drop_d = rx_drop | rx_valid;
        // cmd_ready is still high from the accept on the first cycle here.
        if (done_cnt != '0 && cmd_ready) begin
          tx_valid_d = 1'b1;
          state_d    = SEND_RESP;
          if (cmd == 3'd0) begin
            tx_data_d = 8'hA0;
            tx_buf_d  = SR_W'(data_out);
            tx_rem_d  = CNT_W'(PAYLOAD_BYTES);
          end else begin
            tx_data_d = 8'hA1;
            tx_rem_d  = '0;
          end
        end else if (done_cnt == DONE_W'(DONE_TIMEOUT)) begin
          tx_data_d  = 8'hE1;
          tx_valid_d = 1'b1;
          tx_rem_d   = '0;
          state_d    = SEND_RESP;
        end else begin
          done_d = done_cnt + 1'b1;
        end
      end

      SEND_RESP: begin
        rx_drop_d = rx_drop | rx_valid;
        if (tx_valid && tx_ready) begin
          if (tx_rem == '0) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            tx_data_d = tx_buf[SR_W-1 -: 8];
            tx_buf_d  = {tx_buf[SR_W-9:0], 8'h00};
            tx_rem_d  = tx_rem - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      done_cnt  <= '0;
      tx_buf    <= '0;
      tx_rem    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd       <= '0;
      data_in   <= '0;
      rx_drop   <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      byte_cnt  <= byte_cnt_d;
      gap_cnt   <= gap_d;
      done_cnt  <= done_d;
      tx_buf    <= tx_buf_d;
      tx_rem    <= tx_rem_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      cmd_valid <= cmd_valid_d;
      cmd       <= cmd_d;
      data_in   <= data_in_d;
      rx_drop   <= rx_drop_d;
    end
  end

endmodule

// File: tb/tb_sreg_host_bridge.sv
// Bench for sreg_host_bridge: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_sreg_host_bridge;

  localparam int unsigned DATA_W  = 42;
  localparam int unsigned RX_TO   = 100;
  localparam int unsigned DONE_TO = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [DATA_W-1:0] data_in;
  logic              cmd_ready = 1'b1;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              rx_drop;

  logic [DATA_W-1:0] ctl_word = '0;
  int unsigned       ctl_busy = 2;
  bit                ctl_stuck = 1'b0;
  bit                rnd_ready = 1'b0;
  int                n_cmp = 0;
  int                n_fail = 0;
  byte unsigned      tx_q[$];
  logic [44:0]       cmd_q[$];

  assign data_out = ctl_word;

  always #5 clk = ~clk;

  sreg_host_bridge #(
    .DATA_W      (DATA_W),
    .RX_TIMEOUT  (RX_TO),
    .DONE_TIMEOUT(DONE_TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .data_in  (data_in),
    .cmd_ready(cmd_ready),
    .data_out (data_out),
    .busy     (busy),
    .rx_drop  (rx_drop)
  );

  // Transfers that will complete at the coming rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (rst_n && cmd_valid && cmd_ready) cmd_q.push_back({cmd, data_in});
  end

  // Controller: holds ready one cycle after accept, then busy, then ready again.
  initial forever begin
    @(negedge clk);
    if (rst_n && cmd_valid && cmd_ready) begin
      if (cmd == 3'd1) ctl_word = data_in;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      if (!ctl_stuck) begin
        repeat (ctl_busy) @(posedge clk);
        #1;
        cmd_ready = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d required 0", n_fail);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [47:0] p, input int unsigned gap_max);
    send_byte(op);
    if (op == 8'h01)
      for (int i = 5; i >= 0; i--) begin
        repeat ($urandom_range(0, gap_max)) tick();
        send_byte(p[i*8 +: 8]);
      end
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_wait", busy, 1'b0);
  endtask

  task automatic clear_q();
    tx_q.delete();
    cmd_q.delete();
  endtask

  task automatic score(input string tag, input bit has_cmd, input logic [2:0] code,
                       input logic [41:0] data, input bit chk_data,
                       input int unsigned len, input logic [55:0] resp);
    logic [55:0] got;
    got = '0;
    check({tag, "_ncmd"}, cmd_q.size(), has_cmd);
    if (cmd_q.size() > 0) begin
      check({tag, "_cmd"}, cmd_q[0][44:42], code);
      if (chk_data) check({tag, "_data"}, cmd_q[0][41:0], data);
    end
    check({tag, "_nresp"}, tx_q.size(), len);
    foreach (tx_q[i]) got = {got[47:0], tx_q[i]};
    check({tag, "_resp"}, got, resp);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [47:0] pay;
    logic [41:0] word;
    bit          has_cmd;
    logic [2:0]  code;
    logic [41:0] data;
    bit          chk_data;
    int unsigned len;
    logic [55:0] resp;
  } vec_t;

  vec_t vt[8];

  initial begin
    int unsigned k, bad, kind;
    bit          saw;
    logic [7:0]  op;
    logic [47:0] p;
    logic [41:0] mdl_word;

    vt[0] = '{8'h01, 48'h0003FF001234, 42'h0,           1'b1, 3'd1, 42'h3FF001234,  1'b1, 1, 56'hA1};
    vt[1] = '{8'h00, 48'h0,            42'h2AAAAAA5555, 1'b1, 3'd0, 42'h0,          1'b0, 7, 56'hA002AAAAAA5555};
    vt[2] = '{8'h07, 48'h0,            42'h0,           1'b0, 3'd0, 42'h0,          1'b0, 1, 56'hEE};
    vt[3] = '{8'hFF, 48'h0,            42'h0,           1'b0, 3'd0, 42'h0,          1'b0, 1, 56'hEE};
    vt[4] = '{8'h01, 48'hFFFFFFFFFFFF, 42'h0,           1'b1, 3'd1, 42'h3FFFFFFFFFF, 1'b1, 1, 56'hA1};
    vt[5] = '{8'h00, 48'h0,            42'h0,           1'b1, 3'd0, 42'h0,          1'b0, 7, 56'hA0000000000000};
    vt[6] = '{8'h00, 48'h0,            42'h3FFFFFFFFFF, 1'b1, 3'd0, 42'h0,          1'b0, 7, 56'hA003FFFFFFFFFF};
    vt[7] = '{8'h01, 48'hABCDEF012345, 42'h0,           1'b1, 3'd1, 42'h3CDEF012345, 1'b1, 1, 56'hA1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {tx_data, tx_valid, cmd_valid, cmd, data_in, rx_drop}, '0);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      ctl_word = vt[i].word;
      clear_q();
      send_frame(vt[i].op, vt[i].pay, 1);
      wait_idle(200);
      score($sformatf("vec%0d", i), vt[i].has_cmd, vt[i].code, vt[i].data,
            vt[i].chk_data, vt[i].len, vt[i].resp);
      tick();
    end

    // Transmitter stalls on the first READ response byte.
    ctl_word = 42'h2AAAAAA5555;
    clear_q();
    tx_ready = 1'b0;
    send_frame(8'h00, '0, 0);
    k = 0;
    while (!tx_valid && k < 100) begin
      tick();
      k++;
    end
    check("stall_valid", tx_valid, 1'b1);
    bad = 0;
    repeat (20) begin
      tick();
      if (!tx_valid || tx_data !== 8'hA0) bad++;
    end
    check("stall_hold", bad, 0);
    tx_ready = 1'b1;
    wait_idle(100);
    score("stall", 1'b1, 3'd0, '0, 1'b0, 7, 56'hA002AAAAAA5555);

    // Randomized frames against the frame-level model.
    ctl_word = 42'h15555555555;
    mdl_word = 42'h15555555555;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      p = {16'($urandom), 32'($urandom)};
      if (kind < 2)      op = 8'h00;
      else if (kind < 4) op = 8'h01;
      else               op = 8'($urandom_range(2, 255));
      ctl_busy = $urandom_range(1, 4);
      clear_q();
      rnd_ready = 1'b1;
      send_frame(op, p, 3);
      wait_idle(500);
      rnd_ready = 1'b0;
      tx_ready = 1'b1;
      if (op == 8'h00) begin
        score($sformatf("rnd%0d", f), 1'b1, 3'd0, '0, 1'b0, 7, {8'hA0, 6'b0, mdl_word});
      end else if (op == 8'h01) begin
        mdl_word = p[41:0];
        score($sformatf("rnd%0d", f), 1'b1, 3'd1, p[41:0], 1'b1, 1, 56'hA1);
      end else begin
        score($sformatf("rnd%0d", f), 1'b0, 3'd0, '0, 1'b0, 1, 56'hEE);
      end
      tick();
    end
    check("rnd_drop", rx_drop, 1'b0);

    // Payload gap timeout after two bytes.
    clear_q();
    send_byte(8'h01);
    tick();
    send_byte(8'h12);
    send_byte(8'h34);
    k = 0;
    saw = 1'b0;
    while (!tx_valid && k < 300) begin
      tick();
      k++;
      if (cmd_valid) saw = 1'b1;
    end
    check("rxto_lat", k, RX_TO + 1);
    check("rxto_nocmd", saw, 1'b0);
    wait_idle(50);
    score("rxto", 1'b0, 3'd0, '0, 1'b0, 1, 56'hE0);
    check("rxto_drop", rx_drop, 1'b0);

    // Controller never completes; an extra byte arrives while waiting.
    ctl_stuck = 1'b1;
    clear_q();
    send_frame(8'h00, '0, 0);
    k = 0;
    while (cmd_q.size() == 0 && k < 50) begin
      tick();
      k++;
    end
    check("dto_hs", cmd_q.size(), 1);
    tick();
    tick();
    send_byte(8'h00);
    check("dto_drop", rx_drop, 1'b1);
    check("dto_busy", busy, 1'b1);
    wait_idle(200);
    score("dto", 1'b1, 3'd0, '0, 1'b0, 1, 56'hE1);
    ctl_stuck = 1'b0;
    cmd_ready = 1'b1;
    tick();

    // Reset while a command is held waiting for the controller.
    cmd_ready = 1'b0;
    clear_q();
    send_frame(8'h00, '0, 0);
    bad = 0;
    repeat (5) begin
      if (!cmd_valid) bad++;
      tick();
    end
    check("hold_valid", bad, 0);
    check("hold_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", rx_drop, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    tick();
    ctl_word = 42'h123456789AB;
    clear_q();
    send_frame(8'h00, '0, 0);
    wait_idle(200);
    score("post_rst", 1'b1, 3'd0, '0, 1'b0, 7, 56'hA0_0123456789AB);

    // A byte landing on the timeout cycle is dropped.
    clear_q();
    send_byte(8'h01);
    send_byte(8'h77);
    repeat (RX_TO) tick();
    send_byte(8'h55);
    check("tie_valid", tx_valid, 1'b1);
    check("tie_drop", rx_drop, 1'b1);
    wait_idle(50);
    score("tie", 1'b0, 3'd0, '0, 1'b0, 1, 56'hE0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
